// File: rtl/hdmi_timing_sched.sv
// Video timing generator with a one-per-line, 32-beat data-island scheduler placed in horizontal blanking.
// Outputs lag the counters by one cycle; pkt_ready is high only in island cycles, and a missing beat goes out as zeros.
module hdmi_timing_sched #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned GUARD    = 12
) (
  input  logic        pix_clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        pkt_valid,
  input  logic [11:0] pkt_data,
  output logic        pkt_ready,
  output logic        hsync,
  output logic        vsync,
  output logic        vde,
  output logic        ade,
  output logic [3:0]  aux0_din,
  output logic [3:0]  aux1_din,
  output logic [3:0]  aux2_din,
  output logic [11:0] hcount,
  output logic [10:0] vcount,
  output logic        frame_start,
  output logic        underrun
);
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] WIN_LO   = 12'(H_ACTIVE + GUARD);
  localparam logic [11:0] WIN_HI   = 12'(H_TOTAL - GUARD - 32);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {IDLE = 1'b0, ISLAND = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [4:0]  beat;
  logic        line_used;
  logic        island_go;
  logic [11:0] h_next;
  logic        vde_d, hs_d, vs_d, fs_d;
  logic        in_island;
  logic [9:0]  beat_d;

  // The window test uses the column the first island beat will occupy.
  always_comb begin
    h_next    = (hcount == H_LAST) ? 12'd0 : hcount + 12'd1;
    island_go = enable && pkt_valid && !line_used && (h_next >= WIN_LO) && (h_next <= WIN_HI);
    state_nxt = state;
    case (state)
      IDLE:    if (island_go) state_nxt = ISLAND;
      ISLAND:  if (!enable || beat == 5'd31) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    vde_d     = enable && (hcount < H_ACT) && (vcount < V_ACT);
    hs_d      = (enable && hcount >= HS_START && hcount < HS_END) ? HS_POL : ~HS_POL;
    vs_d      = (enable && vcount >= VS_START && vcount < VS_END) ? VS_POL : ~VS_POL;
    fs_d      = enable && (hcount == 12'd0) && (vcount == 11'd0);
    in_island = enable && (state == ISLAND);
    beat_d    = (in_island && pkt_valid) ? {pkt_data[11:4], pkt_data[3:2]} : 10'd0;
  end

  assign pkt_ready = (state == ISLAND);

  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      hcount <= 12'd0;
      vcount <= 11'd0;
    end else if (!enable) begin
      hcount <= 12'd0;
      vcount <= 11'd0;
    end else begin
      hcount <= h_next;
      if (hcount == H_LAST) vcount <= (vcount == V_LAST) ? 11'd0 : vcount + 11'd1;
    end
  end

  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      beat      <= 5'd0;
      line_used <= 1'b0;
    end else begin
      state <= state_nxt;
      beat  <= (state == ISLAND && state_nxt == ISLAND) ? beat + 5'd1 : 5'd0;
      if (state == IDLE && state_nxt == ISLAND) line_used <= 1'b1;
      else if (hcount == 12'd0)                 line_used <= 1'b0;
    end
  end

  // aux0 low bits always mirror the sync levels registered in the same cycle.
  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      vde         <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      frame_start <= 1'b0;
      ade         <= 1'b0;
      aux0_din    <= {2'b00, ~VS_POL, ~HS_POL};
      aux1_din    <= 4'd0;
      aux2_din    <= 4'd0;
      underrun    <= 1'b0;
    end else begin
      vde         <= vde_d;
      hsync       <= hs_d;
      vsync       <= vs_d;
      frame_start <= fs_d;
      ade         <= in_island;
      aux2_din    <= beat_d[9:6];
      aux1_din    <= beat_d[5:2];
      aux0_din    <= {beat_d[1:0], vs_d, hs_d};
      if (in_island && !pkt_valid) underrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_hdmi_timing_sched.sv
// Bench for hdmi_timing_sched on a reduced 128x15 raster: island beats go through a scoreboard queue,
// while a reference counter model and hand-computed directed checks cover sync, enable and reset behaviour.
module tb_hdmi_timing_sched;
  // Raster: H 64+16+24+24 = 128, V 8+2+2+3 = 15, GUARD 12 -> island window start columns 76..84.
  localparam int HT = 128;
  localparam int VT = 15;

  logic        pix_clk;
  logic        rst;
  logic        enable;
  logic        pkt_valid;
  logic [11:0] pkt_data;
  logic        pkt_ready, hsync, vsync, vde, ade, frame_start, underrun;
  logic [3:0]  aux0_din, aux1_din, aux2_din;
  logic [11:0] hcount;
  logic [10:0] vcount;

  int          vecs = 0;
  int          errs = 0;
  logic [11:0] sb[$];
  logic [11:0] e;
  logic [11:0] dctr;
  bit          exp_ade;
  int          n_vde, n_hs, n_vs, n_fs;

  int rh, rv;
  bit e_vde, e_hs, e_vs, e_fs;

  hdmi_timing_sched #(
    .H_ACTIVE(64), .H_FP(16), .H_SYNC(24), .H_BP(24),
    .V_ACTIVE(8),  .V_FP(2),  .V_SYNC(2),  .V_BP(3),
    .HS_POL(1'b0), .VS_POL(1'b0), .GUARD(12)
  ) dut (
    .pix_clk(pix_clk), .rst(rst), .enable(enable),
    .pkt_valid(pkt_valid), .pkt_data(pkt_data), .pkt_ready(pkt_ready),
    .hsync(hsync), .vsync(vsync), .vde(vde), .ade(ade),
    .aux0_din(aux0_din), .aux1_din(aux1_din), .aux2_din(aux2_din),
    .hcount(hcount), .vcount(vcount),
    .frame_start(frame_start), .underrun(underrun)
  );

  initial begin
    pix_clk = 1'b0;
    forever #5 pix_clk = ~pix_clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference raster counters and the sync/vde/frame_start levels expected one cycle later.
  always @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      rh <= 0; rv <= 0;
      e_vde <= 1'b0; e_hs <= 1'b1; e_vs <= 1'b1; e_fs <= 1'b0;
    end else begin
      e_vde <= enable && rh < 64 && rv < 8;
      e_hs  <= !(enable && rh >= 80 && rh < 104);
      e_vs  <= !(enable && rv >= 10 && rv < 12);
      e_fs  <= enable && rh == 0 && rv == 0;
      if (!enable) begin
        rh <= 0; rv <= 0;
      end else begin
        rh <= (rh == HT - 1) ? 0 : rh + 1;
        if (rh == HT - 1) rv <= (rv == VT - 1) ? 0 : rv + 1;
      end
    end
  end

  always @(negedge pix_clk) begin
    if (!rst) begin
      check("hcount", hcount, rh);
      check("vcount", vcount, rv);
      check("vde", vde, e_vde);
      check("hsync", hsync, e_hs);
      check("vsync", vsync, e_vs);
      check("frame_start", frame_start, e_fs);
      if (!ade) begin
        check("aux0_idle", aux0_din, {2'b00, e_vs, e_hs});
        check("aux1_idle", aux1_din, 0);
        check("aux2_idle", aux2_din, 0);
      end
    end
  end

  // Scoreboard monitor: every ade cycle consumes one expected island beat.
  always @(negedge pix_clk) begin
    if (!rst && ade) begin
      if (sb.size() == 0) begin
        vecs++; errs++;
        $display("FAIL sb_pop: ade high with no expected beat, aux2/1/0=%h/%h/%h at %0t",
                 aux2_din, aux1_din, aux0_din, $time);
      end else begin
        e = sb.pop_front();
        check("aux2_beat", aux2_din, e[11:8]);
        check("aux1_beat", aux1_din, e[7:4]);
        check("aux0_beat", aux0_din, e[3:0]);
      end
    end
  end

  // One cycle, entered and left at a negedge. rdy_exp is the hand-derived island membership of column rh.
  task automatic step(input bit v, input bit rdy_exp, input bit en = 1'b1);
    bit hs_x, vs_x;
    enable    = en;
    pkt_valid = v;
    pkt_data  = dctr;
    dctr      = dctr + 12'h135;
    hs_x = !(en && rh >= 80 && rh < 104);
    vs_x = !(en && rv >= 10 && rv < 12);
    check("pkt_ready", pkt_ready, rdy_exp);
    check("ade", ade, exp_ade);
    if (vde) n_vde++;
    if (!hsync) n_hs++;
    if (!vsync) n_vs++;
    if (frame_start) n_fs++;
    if (rdy_exp && en)
      sb.push_back(v ? {pkt_data[11:4], pkt_data[3:2], vs_x, hs_x} : {8'h00, 2'b00, vs_x, hs_x});
    exp_ade = rdy_exp && en;
    @(negedge pix_clk);
  endtask

  // A full line starting at column 0: valid over [v_from, v_to], island expected at h0..h0+31 (h0<0: none),
  // and valid withheld on island beat index 'drop'.
  task automatic line(input int v_from, input int v_to, input int h0, input int drop);
    for (int h = 0; h < HT; h++) begin
      automatic bit isl = (h0 >= 0) && (h >= h0) && (h < h0 + 32);
      automatic bit v   = (h >= v_from) && (h <= v_to) && !(isl && (h - h0 == drop));
      step(v, isl);
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; pkt_valid = 1'b0; pkt_data = 12'h000;
    dctr = 12'h0A5; exp_ade = 1'b0;
    n_vde = 0; n_hs = 0; n_vs = 0; n_fs = 0;
    repeat (2) @(negedge pix_clk);
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_vde", vde, 0);
    check("rst_ade", ade, 0);
    check("rst_ready", pkt_ready, 0);
    check("rst_hcount", hcount, 0);
    check("rst_vcount", vcount, 0);
    check("rst_fs", frame_start, 0);
    check("rst_underrun", underrun, 0);
    check("rst_aux0", aux0_din, 4'b0011);
    check("rst_aux1", aux1_din, 0);
    check("rst_aux2", aux2_din, 0);
    rst = 1'b0;

    // Released from reset but disabled: counters hold at zero.
    repeat (3) step(1'b0, 1'b0, 1'b0);
    check("hold_hcount", hcount, 0);

    // One full frame with no packets: 8 lines x 64 vde, 15 x 24 hsync, 2 x 128 vsync, one frame_start.
    n_vde = 0; n_hs = 0; n_vs = 0; n_fs = 0;
    repeat (HT * VT) step(1'b0, 1'b0);
    check("frame_vde_cycles", n_vde, 512);
    check("frame_hsync_cycles", n_hs, 360);
    check("frame_vsync_cycles", n_vs, 256);
    check("frame_fs_pulses", n_fs, 1);

    line(0, HT - 1, 76, -1);          // continuous source, lines 0 and 1
    line(0, HT - 1, 76, -1);
    check("no_underrun", underrun, 0);
    line(84, HT - 1, -1, -1);         // request one column too late for this line
    line(0, 107, 76, -1);             // served at the next line's window start
    line(83, HT - 1, 84, -1);         // request that just fits mid-window
    line(0, HT - 1, 76, 10);          // beat 10 missing
    check("underrun_set", underrun, 1);
    line(1, 0, -1, -1);               // idle line
    check("underrun_sticky", underrun, 1);
    repeat (5) line(0, HT - 1, 76, -1);  // lines 7..11, including vertical blanking and vsync lines

    // Abort at island beat 5 of line 12.
    for (int h = 0; h <= 80; h++) step(1'b1, h >= 76);
    step(1'b1, 1'b1, 1'b0);
    check("abort_hcount", hcount, 0);
    check("abort_ade", ade, 0);
    check("abort_ready", pkt_ready, 0);
    check("abort_hsync", hsync, 1);
    check("abort_vde", vde, 0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    n_fs = 0;
    line(0, HT - 1, 76, -1);
    check("resume_fs_pulses", n_fs, 1);
    check("sb_drained", sb.size(), 0);

    // Asynchronous reset in the middle of an island while hsync is active.
    for (int h = 0; h < 90; h++) step(1'b1, h >= 76);
    check("pre_rst_hsync", hsync, 0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_hsync", hsync, 1);
    check("mid_rst_vsync", vsync, 1);
    check("mid_rst_vde", vde, 0);
    check("mid_rst_ade", ade, 0);
    check("mid_rst_ready", pkt_ready, 0);
    check("mid_rst_hcount", hcount, 0);
    check("mid_rst_underrun", underrun, 0);
    check("mid_rst_aux0", aux0_din, 4'b0011);
    sb.delete();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
